// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: default widths and a one-hot check.
package reg_scoreboard_pkg;

  localparam int unsigned NREG_DEF     = 4;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ONEHOT_MAX_W = 32;

  // True when exactly one bit is set; callers zero-extend narrower masks.
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the shared register-file write port.
module wb_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic ready0_c,
  output logic ready1_c
);

  // last_q = 1 means source 1 won most recently, so source 0 wins the next conflict.
  logic last_q;
  logic last_d;

  always_comb begin
    ready0_c = valid0 & (~valid1 | last_q);
    ready1_c = valid1 & (~valid0 | ~last_q);
    last_d   = last_q;
    if (ready0_c) begin
      last_d = 1'b0;
    end else if (ready1_c) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register reservation scoreboard: RAW/WAW issue stall plus write-back arbitration
// onto the single register-file write port.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [NREG-1:0]   dec_rd_exp,
  input  logic [NREG-1:0]   dec_rs_exp,
  input  logic [NREG-1:0]   dec_wb_exp,
  input  logic              exec_stall,
  output logic              dec_stall,
  output logic              issue,
  input  logic              wb0_valid,
  input  logic [NREG-1:0]   wb0_exp,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [NREG-1:0]   wb1_exp,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [NREG-1:0]   rf_wb_exp,
  output logic [DATA_W-1:0] rf_wb_data,
  output logic [NREG-1:0]   w_reserve,
  output logic              err
);

  logic [NREG-1:0]   res_q, res_d;
  logic              rf_we_q, rf_we_d;
  logic [NREG-1:0]   rf_exp_q, rf_exp_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              err_q, err_d;

  logic              gnt_any;
  logic [NREG-1:0]   gnt_exp;
  logic [DATA_W-1:0] gnt_data;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;
  logic              hazard;

  wb_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid0   (wb0_valid),
    .valid1   (wb1_valid),
    .ready0_c (wb0_ready),
    .ready1_c (wb1_ready)
  );

  // Hazard uses registered reservations only; a same-cycle release does not bypass.
  always_comb begin
    hazard    = |((dec_rd_exp | dec_rs_exp | dec_wb_exp) & res_q);
    dec_stall = dec_valid & (exec_stall | hazard);
    issue     = dec_valid & ~dec_stall;
  end

  always_comb begin
    gnt_any   = wb0_ready | wb1_ready;
    gnt_exp   = wb0_ready ? wb0_exp  : wb1_exp;
    gnt_data  = wb0_ready ? wb0_data : wb1_data;
    set_mask  = issue   ? dec_wb_exp : '0;
    clr_mask  = gnt_any ? gnt_exp    : '0;

    // Clear wins over a simultaneous set on the same bit.
    res_d     = (res_q | set_mask) & ~clr_mask;

    rf_we_d   = gnt_any;
    rf_exp_d  = gnt_any ? gnt_exp  : rf_exp_q;
    rf_data_d = gnt_any ? gnt_data : rf_data_q;

    err_d = err_q;
    if (gnt_any && (!is_onehot(ONEHOT_MAX_W'(gnt_exp)) || (|(gnt_exp & ~res_q)))) begin
      err_d = 1'b1;
    end
    if (issue && (dec_wb_exp != '0) && !is_onehot(ONEHOT_MAX_W'(dec_wb_exp))) begin
      err_d = 1'b1;
    end
    if (|(set_mask & clr_mask)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_exp_q  <= '0;
      rf_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      res_q     <= res_d;
      rf_we_q   <= rf_we_d;
      rf_exp_q  <= rf_exp_d;
      rf_data_q <= rf_data_d;
      err_q     <= err_d;
    end
  end

  assign w_reserve  = res_q;
  assign rf_we      = rf_we_q;
  assign rf_wb_exp  = rf_exp_q;
  assign rf_wb_data = rf_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized bench for reg_scoreboard against a behavioural model.
module tb_reg_scoreboard;

  localparam int unsigned NREG   = 4;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dec_valid = 1'b0;
  logic [NREG-1:0]   dec_rd_exp = '0;
  logic [NREG-1:0]   dec_rs_exp = '0;
  logic [NREG-1:0]   dec_wb_exp = '0;
  logic              exec_stall = 1'b0;
  logic              dec_stall;
  logic              issue;
  logic              wb0_valid = 1'b0;
  logic [NREG-1:0]   wb0_exp = '0;
  logic [DATA_W-1:0] wb0_data = '0;
  logic              wb0_ready;
  logic              wb1_valid = 1'b0;
  logic [NREG-1:0]   wb1_exp = '0;
  logic [DATA_W-1:0] wb1_data = '0;
  logic              wb1_ready;
  logic              rf_we;
  logic [NREG-1:0]   rf_wb_exp;
  logic [DATA_W-1:0] rf_wb_data;
  logic [NREG-1:0]   w_reserve;
  logic              err;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit              res_m[NREG];
  bit              last_wb1_m;
  bit              err_m;
  bit              rf_we_m;
  logic [NREG-1:0] rf_exp_m;
  logic [31:0]     rf_data_m;

  reg_scoreboard #(.NREG(NREG), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rd_exp(dec_rd_exp), .dec_rs_exp(dec_rs_exp),
    .dec_wb_exp(dec_wb_exp), .exec_stall(exec_stall),
    .dec_stall(dec_stall), .issue(issue),
    .wb0_valid(wb0_valid), .wb0_exp(wb0_exp), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_exp(wb1_exp), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_we(rf_we), .rf_wb_exp(rf_wb_exp), .rf_wb_data(rf_wb_data),
    .w_reserve(w_reserve), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] res_packed();
    logic [NREG-1:0] r;
    for (int i = 0; i < NREG; i++) r[i] = res_m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) res_m[i] = 1'b0;
    last_wb1_m = 1'b1;
    err_m      = 1'b0;
    rf_we_m    = 1'b0;
    rf_exp_m   = '0;
    rf_data_m  = '0;
  endtask

  task automatic chk_regs(input string pfx);
    chk({pfx, "_w_reserve"},  32'(w_reserve),  32'(res_packed()));
    chk({pfx, "_rf_we"},      32'(rf_we),      32'(rf_we_m));
    chk({pfx, "_rf_wb_exp"},  32'(rf_wb_exp),  32'(rf_exp_m));
    chk({pfx, "_rf_wb_data"}, 32'(rf_wb_data), rf_data_m);
    chk({pfx, "_err"},        32'(err),        32'(err_m));
  endtask

  // Async reset: registered outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_w_reserve",  32'(w_reserve),  32'd0);
    chk("rst_rf_we",      32'(rf_we),      32'd0);
    chk("rst_rf_wb_exp",  32'(rf_wb_exp),  32'd0);
    chk("rst_rf_wb_data", 32'(rf_wb_data), 32'd0);
    chk("rst_err",        32'(err),        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registers.
  task automatic cycle();
    bit hz, st, is, g0, g1;
    bit old_res[NREG];
    logic [NREG-1:0] gexp;
    logic [31:0] gdata;
    hz = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (res_m[i] && (dec_rd_exp[i] || dec_rs_exp[i] || dec_wb_exp[i])) hz = 1'b1;
    st = dec_valid && (exec_stall || hz);
    is = dec_valid && !st;
    if (wb0_valid && wb1_valid) begin
      g0 = last_wb1_m;
      g1 = !last_wb1_m;
    end else begin
      g0 = wb0_valid;
      g1 = wb1_valid;
    end
    @(negedge clk);
    chk("dec_stall", 32'(dec_stall), 32'(st));
    chk("issue",     32'(issue),     32'(is));
    chk("wb0_ready", 32'(wb0_ready), 32'(g0));
    chk("wb1_ready", 32'(wb1_ready), 32'(g1));
    @(posedge clk);
    #1;
    old_res = res_m;
    if (is) begin
      for (int i = 0; i < NREG; i++) if (dec_wb_exp[i]) res_m[i] = 1'b1;
      if (dec_wb_exp != '0 && $countones(dec_wb_exp) != 1) err_m = 1'b1;
    end
    if (g0 || g1) begin
      gexp  = g0 ? wb0_exp : wb1_exp;
      gdata = g0 ? 32'(wb0_data) : 32'(wb1_data);
      if ($countones(gexp) != 1) err_m = 1'b1;
      for (int i = 0; i < NREG; i++) begin
        if (gexp[i]) begin
          if (!old_res[i]) err_m = 1'b1;
          if (is && dec_wb_exp[i]) err_m = 1'b1;
          res_m[i] = 1'b0;
        end
      end
      rf_we_m    = 1'b1;
      rf_exp_m   = gexp;
      rf_data_m  = gdata;
      last_wb1_m = g1;
    end else begin
      rf_we_m = 1'b0;
    end
    chk_regs("cyc");
  endtask

  function automatic logic [NREG-1:0] rand_onehot_or_zero();
    if ($urandom_range(0, 3) == 0) return '0;
    return NREG'(1) << $urandom_range(0, NREG - 1);
  endfunction

  function automatic logic [NREG-1:0] rand_wb_target();
    int idx[$];
    for (int i = 0; i < NREG; i++) if (res_m[i]) idx.push_back(i);
    if ($urandom_range(0, 15) == 0) return NREG'($urandom);
    if (idx.size() == 0) return NREG'(1) << $urandom_range(0, NREG - 1);
    return NREG'(1) << idx[$urandom_range(0, idx.size() - 1)];
  endfunction

  initial begin
    model_reset();
    #2;
    // Reset, then issue a write to r1 straight out of reset
    do_reset();
    dec_valid  = 1'b1;
    dec_wb_exp = 4'b0010;
    #1;
    chk("rel_issue", 32'(issue), 32'd1);
    cycle();
    chk("rel_w_reserve", 32'(w_reserve), 32'h2);

    // RAW on r1, released by wb0
    dec_wb_exp = '0;
    dec_rd_exp = 4'b0010;
    wb0_valid  = 1'b1;
    wb0_exp    = 4'b0010;
    wb0_data   = 32'h0000_00AB;
    #1;
    chk("raw_stall", 32'(dec_stall), 32'd1);
    cycle();
    chk("raw_rf_we",   32'(rf_we),      32'd1);
    chk("raw_rf_data", 32'(rf_wb_data), 32'h0000_00AB);
    chk("raw_res",     32'(w_reserve),  32'd0);
    wb0_valid = 1'b0;
    #1;
    chk("raw_unstall", 32'(dec_stall), 32'd0);
    cycle();
    dec_rd_exp = '0;

    // exec_stall without hazard
    dec_wb_exp = 4'b0100;
    exec_stall = 1'b1;
    #1;
    chk("xs_stall", 32'(dec_stall), 32'd1);
    chk("xs_issue", 32'(issue),     32'd0);
    cycle();
    chk("xs_res", 32'(w_reserve), 32'd0);
    exec_stall = 1'b0;
    dec_valid  = 1'b0;
    dec_wb_exp = '0;

    // Conflict from a fresh reset: wb0 first, then wb1
    do_reset();
    dec_valid  = 1'b1;
    dec_wb_exp = 4'b0001;
    cycle();
    dec_wb_exp = 4'b1000;
    cycle();
    dec_valid  = 1'b0;
    dec_wb_exp = '0;
    wb0_valid = 1'b1; wb0_exp = 4'b0001; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_exp = 4'b1000; wb1_data = 32'h22;
    #1;
    chk("cf1_wb0_ready", 32'(wb0_ready), 32'd1);
    chk("cf1_wb1_ready", 32'(wb1_ready), 32'd0);
    cycle();
    chk("cf1_rf_data", 32'(rf_wb_data), 32'h11);
    wb0_valid = 1'b0;
    #1;
    chk("cf2_wb1_ready", 32'(wb1_ready), 32'd1);
    cycle();
    chk("cf2_rf_we",   32'(rf_we),      32'd1);
    chk("cf2_rf_data", 32'(rf_wb_data), 32'h22);
    chk("cf2_res",     32'(w_reserve),  32'd0);
    wb1_valid = 1'b0;

    // Write-back to unreserved r2 raises sticky err
    wb1_valid = 1'b1; wb1_exp = 4'b0100; wb1_data = 32'h33;
    cycle();
    chk("ur_rf_we", 32'(rf_we), 32'd1);
    chk("ur_err",   32'(err),   32'd1);
    wb1_valid = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    chk("ur_err_sticky", 32'(err), 32'd1);
    do_reset();

    // Reset mid-operation with all registers reserved and wb0 pending
    dec_valid = 1'b1;
    for (int k = 0; k < NREG; k++) begin
      dec_wb_exp = NREG'(1) << k;
      cycle();
    end
    chk("full_res", 32'(w_reserve), 32'hF);
    dec_valid  = 1'b0;
    dec_wb_exp = '0;
    wb0_valid = 1'b1; wb0_exp = 4'b0001; wb0_data = 32'h55;
    #2;
    do_reset();
    wb0_valid = 1'b0;
    cycle();
    chk("mid_no_write", 32'(rf_we), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      if (k % 100 == 99) do_reset();
      dec_valid  = 1'($urandom_range(0, 1));
      dec_rd_exp = rand_onehot_or_zero();
      dec_rs_exp = rand_onehot_or_zero();
      dec_wb_exp = ($urandom_range(0, 19) == 0) ? NREG'($urandom) : rand_onehot_or_zero();
      exec_stall = ($urandom_range(0, 3) == 0);
      wb0_valid  = ($urandom_range(0, 2) == 0);
      wb0_exp    = rand_wb_target();
      wb0_data   = $urandom;
      wb1_valid  = ($urandom_range(0, 2) == 0);
      wb1_exp    = rand_wb_target();
      wb1_data   = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard controller and write-back arbiter for the 4-entry register file.
- Tracks per-register write reservations and stalls decode→exec issue on RAW/WAW hazards.
- Shares the single register-file write port between two write-back sources: ALU (wb0) and load unit (wb1).
- Sits between insndec, exec/load units and the register file; it replaces ad-hoc reservation logic inside the register file.

Parameters:
- NREG, 4, number of architectural registers (one-hot width of all *_exp masks).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- dec_valid  input  1  decode stage holds a valid instruction.
- dec_rd_exp  input  NREG  one-hot (or zero) first source register mask.
- dec_rs_exp  input  NREG  one-hot (or zero) second source register mask.
- dec_wb_exp  input  NREG  one-hot (or zero) destination mask; zero = no write.
- exec_stall  input  1  exec stage cannot accept.
- dec_stall  output  1  decode must hold its instruction this cycle.
- issue  output  1  dec_valid & ~dec_stall; instruction transfers this cycle.
- wb0_valid  input  1  ALU write-back request.
- wb0_exp  input  NREG  ALU destination, one-hot.
- wb0_data  input  DATA_W  ALU result.
- wb0_ready  output  1  ALU request granted this cycle.
- wb1_valid, wb1_exp, wb1_data, wb1_ready: same meanings as wb0_*, for the load unit.
- rf_we  output  1  register-file write enable.
- rf_wb_exp  output  NREG  register-file write mask.
- rf_wb_data  output  DATA_W  register-file write data.
- w_reserve  output  NREG  current reservation bits.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst=0, async): w_reserve=0, rf_we=0, rf_wb_exp=0, rf_wb_data=0, err=0, last_grant=1 (wb0 wins first conflict).
- Reset mid-operation drops all reservations and any in-flight grant.
- Hazard test:
  - hazard = |((dec_rd_exp | dec_rs_exp | dec_wb_exp) & w_reserve).
  - dec_stall = dec_valid & (exec_stall | hazard). Combinational, uses the registered w_reserve only (no same-cycle release bypass).
- Issue: on issue, w_reserve |= dec_wb_exp at the next edge.
  - The WAW check guarantees that bit was clear.
- Arbitration, combinational grant:
  - Only one valid: that source is granted.
  - Both valid: grant the source not in last_grant (round-robin); last_grant updates on every grant.
  - Ungranted sources hold valid/exp/data stable (ready-valid handshake, no drop).
- Write port: registered, latency 1.
  - Edge after a grant: rf_we=1, rf_wb_exp/rf_wb_data = granted source's exp/data.
  - With no grant: rf_we=0, exp/data hold their previous values.
- Release: the same edge that raises rf_we clears w_reserve bits in the granted exp.
  - New reservations from dec are visible to dec_stall from the following cycle.
  - A waiting reader issues one cycle after the release edge.
- Simultaneous set and clear on the same bit cannot occur legally. If it does, the clear wins and err is set.
- err is set (sticky until reset) on any of:
  - a granted exp whose bit is not reserved;
  - a granted exp that is not one-hot;
  - a non-one-hot, non-zero dec_wb_exp on issue.

Decomposition:
- Shared package (defs): NREG, DATA_W defaults, and a one-hot-check function.
- One natural sub-module: wb_rr_arbiter, a 2-way round-robin arbiter with a last_grant flop, clk/rst, valid in, ready out.
- Scoreboard flops, hazard logic and the write-port register stay in reg_scoreboard.

Test Plan:
- Reset release with dec_valid=1, dec_wb_exp=4'b0010, exec_stall=0 → issue=1; w_reserve=4'b0010 next cycle; all outputs 0 during reset.
- RAW: r1 reserved, dec_rd_exp=4'b0010 → dec_stall=1. wb0 granted with exp=4'b0010, data=0x0000_00AB → next edge rf_we=1, rf_wb_data=0x000000AB, w_reserve=0. The following cycle, dec_stall=0.
- Conflict: r0 and r3 reserved, wb0(exp=0001, data=0x11) and wb1(exp=1000, data=0x22) valid together for 2 cycles:
  - cycle 1: wb0_ready=1, wb1_ready=0;
  - cycle 2: wb1_ready=1;
  - rf writes are 0x11 then 0x22 on consecutive cycles; w_reserve ends at 0.
- exec_stall=1 with no hazard → dec_stall=1, issue=0, w_reserve unchanged.
- wb1 write-back to unreserved r2 (exp=0100) → rf_we=1 next cycle and err=1, still 1 after 10 cycles; rst=0 pulse → err=0.
- rst asserted while w_reserve=4'b1111 and wb0_valid=1 → w_reserve=0 and rf_we=0 immediately (async), with no write after release.
